// File: rtl/mux_2x1_tx_if.sv
// mux_2x1_tx_if: lane inputs, ready/overflow status and serialized output of
// the 2:1 transmit mux. The producer/monitor side uses "master", the mux
// uses "slave".
interface mux_2x1_tx_if;
    logic [7:0] data_in_0;
    logic       valid_in_0;
    logic [7:0] data_in_1;
    logic       valid_in_1;
    logic       ready_0;
    logic       ready_1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       overflow;

    modport master (
        output data_in_0, valid_in_0, data_in_1, valid_in_1,
        input  ready_0, ready_1, data_out, valid_out, overflow
    );

    modport slave (
        input  data_in_0, valid_in_0, data_in_1, valid_in_1,
        output ready_0, ready_1, data_out, valid_out, overflow
    );
endinterface

// File: rtl/mux_2x1_tx.sv
// mux_2x1_tx: two DEPTH-word lane FIFOs serialized onto one registered byte
// stream in strict lane0/lane1 alternation, so the receive demux can restore
// the lanes from position alone. A push into a full lane is dropped and sets
// the sticky overflow flag.
// Optional feature macro: MUX_IDLE_BC_EN -- when defined, data_out carries the
// idle comma 8'hBC on cycles without a valid word; otherwise it holds the last
// word.
//
// state | meaning
// LANE0 | next pop comes from lane 0 (sel = 0)
// LANE1 | next pop comes from lane 1 (sel = 1)
module mux_2x1_tx #(
    parameter int DEPTH = 4
) (
    input logic          clk_2f,
    input logic          reset,
    mux_2x1_tx_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem   [2][DEPTH];
    logic [PW-1:0]   r_wptr  [2];
    logic [PW-1:0]   r_rptr  [2];
    logic [CW-1:0]   r_count [2];
    logic [7:0]      r_data_out;
    logic            r_valid_out;
    logic            r_overflow;

    logic [1:0]      w_valid_in;
    logic [7:0]      w_data_in [2];
    logic [1:0]      w_full;
    logic [1:0]      w_empty;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic            w_sel;
    logic [7:0]      w_head;

    assign w_valid_in   = {bus.valid_in_1, bus.valid_in_0};
    assign w_data_in[0] = bus.data_in_0;
    assign w_data_in[1] = bus.data_in_1;
    assign w_sel        = (r_state == LANE1);
    assign w_head       = r_mem[w_sel][r_rptr[w_sel]];

    // Lane status from registered counts; full lanes refuse pushes regardless of a same-cycle pop.
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_push  = '0;
        for (int i = 0; i < 2; i++) begin
            w_full[i]  = (r_count[i] == FULL_CNT);
            w_empty[i] = (r_count[i] == '0);
            w_push[i]  = w_valid_in[i] & ~w_full[i];
        end
    end

    // Selector FSM: pop the selected lane if it has data and move on, otherwise wait on it.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        case (r_state)
            LANE0: begin
                if (!w_empty[0]) begin
                    w_pop[0]    = 1'b1;
                    w_state_nxt = LANE1;
                end
            end
            LANE1: begin
                if (!w_empty[1]) begin
                    w_pop[1]    = 1'b1;
                    w_state_nxt = LANE0;
                end
            end
            default: w_state_nxt = LANE0;
        endcase
    end

    // Selector state register.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state <= LANE0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents need no reset since pointers and counts are cleared.
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= w_data_in[i];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CW'(1);
                    2'b01:   r_count[i] <= r_count[i] - CW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Registered serial output; idle cycles either show the comma or hold the last word.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_data_out  <= 8'h00;
            r_valid_out <= 1'b0;
        end else if (|w_pop) begin
            r_data_out  <= w_head;
            r_valid_out <= 1'b1;
        end else begin
`ifdef MUX_IDLE_BC_EN
            r_data_out  <= 8'hBC;
`else
            r_data_out  <= r_data_out;
`endif
            r_valid_out <= 1'b0;
        end
    end

    // Sticky overflow: any push request that meets a full lane.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (|(w_valid_in & w_full)) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.ready_0   = ~w_full[0];
    assign bus.ready_1   = ~w_full[1];
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_mux_2x1_tx.sv
// tb_mux_2x1_tx: directed scenarios plus randomized traffic against a
// queue-based reference of the 2:1 transmit mux.
module tb_mux_2x1_tx;
    localparam int DEPTH = 4;

    logic clk_2f;
    logic reset;
    mux_2x1_tx_if bus ();

    mux_2x1_tx #(.DEPTH(DEPTH)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_en = 0;

    // Reference: one queue per lane, a lane pointer and the expected outputs.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         m_sel;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovf;
    int         m_n0;
    int         m_n1;

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference update on each edge; asynchronous reset empties everything.
    always @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            q0.delete();
            q1.delete();
            m_sel     = 1'b0;
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            m_n0 = q0.size();
            m_n1 = q1.size();
            if (!m_sel && m_n0 > 0) begin
                exp_data  = q0.pop_front();
                exp_valid = 1'b1;
                m_sel     = 1'b1;
            end else if (m_sel && m_n1 > 0) begin
                exp_data  = q1.pop_front();
                exp_valid = 1'b1;
                m_sel     = 1'b0;
            end else begin
                exp_valid = 1'b0;
`ifdef MUX_IDLE_BC_EN
                exp_data  = 8'hBC;
`endif
            end
            if (bus.valid_in_0) begin
                if (m_n0 >= DEPTH) exp_ovf = 1'b1;
                else q0.push_back(bus.data_in_0);
            end
            if (bus.valid_in_1) begin
                if (m_n1 >= DEPTH) exp_ovf = 1'b1;
                else q1.push_back(bus.data_in_1);
            end
        end
    end

    // Every-cycle comparison against the reference, mid-cycle.
    always @(negedge clk_2f) begin
        if (cmp_en) begin
            check("data_out",  32'(bus.data_out),  32'(exp_data));
            check("valid_out", 32'(bus.valid_out), 32'(exp_valid));
            check("overflow",  32'(bus.overflow),  32'(exp_ovf));
            check("ready_0",   32'(bus.ready_0),   32'(q0.size() < DEPTH));
            check("ready_1",   32'(bus.ready_1),   32'(q1.size() < DEPTH));
        end
    end

    task automatic drive(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        bus.valid_in_0 = v0;
        bus.data_in_0  = d0;
        bus.valid_in_1 = v1;
        bus.data_in_1  = d1;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk_2f);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] outs [$];
    int         nv;
    logic [7:0] idle_exp;

    initial begin
        reset          = 1'b0;
        bus.valid_in_0 = 1'b0;
        bus.data_in_0  = 8'h00;
        bus.valid_in_1 = 1'b0;
        bus.data_in_1  = 8'h00;
        repeat (2) @(posedge clk_2f);
        #1;
        check("rst_data_out",  32'(bus.data_out),  32'h00);
        check("rst_valid_out", 32'(bus.valid_out), 32'h0);
        check("rst_overflow",  32'(bus.overflow),  32'h0);
        check("rst_ready_0",   32'(bus.ready_0),   32'h1);
        check("rst_ready_1",   32'(bus.ready_1),   32'h1);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Basic alternation: A1 on lane 0 then B2 on lane 1.
        drive(1'b1, 8'hA1, 1'b0, 8'h00);
        check("a1_not_yet", 32'(bus.valid_out), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 8'hB2);
        check("a1_data",  32'(bus.data_out),  32'hA1);
        check("a1_valid", 32'(bus.valid_out), 32'h1);
        idle();
        check("b2_data",  32'(bus.data_out),  32'hB2);
        check("b2_valid", 32'(bus.valid_out), 32'h1);
        idle();
`ifdef MUX_IDLE_BC_EN
        idle_exp = 8'hBC;
`else
        idle_exp = 8'hB2;
`endif
        check("idle_valid", 32'(bus.valid_out), 32'h0);
        check("idle_data",  32'(bus.data_out),  32'(idle_exp));

        // Lane 1 alone must not be served while lane 0 is selected.
        drive(1'b0, 8'h00, 1'b1, 8'h11);
        idle();
        check("wait_l0_a", 32'(bus.valid_out), 32'h0);
        idle();
        check("wait_l0_b", 32'(bus.valid_out), 32'h0);
        drive(1'b1, 8'h22, 1'b0, 8'h00);
        idle();
        check("w22_data",  32'(bus.data_out),  32'h22);
        check("w22_valid", 32'(bus.valid_out), 32'h1);
        idle();
        check("w11_data",  32'(bus.data_out),  32'h11);
        check("w11_valid", 32'(bus.valid_out), 32'h1);

        // Lane 0 saturation with lane 1 idle.
        pulse_reset();
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00);
            if (bus.valid_out) nv++;
            if (i == 3) check("sat_ready_e4", 32'(bus.ready_0), 32'h1);
            if (i == 4) begin
                check("sat_ready_e5", 32'(bus.ready_0),  32'h0);
                check("sat_ovf_e5",   32'(bus.overflow), 32'h0);
            end
            if (i == 5) check("sat_ovf_e6", 32'(bus.overflow), 32'h1);
        end
        idle();
        if (bus.valid_out) nv++;
        idle();
        if (bus.valid_out) nv++;
        check("sat_words_out", 32'(nv), 32'd1);
        check("sat_ovf_sticky", 32'(bus.overflow), 32'h1);

        // Both lanes streaming.
        pulse_reset();
        outs.delete();
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b1, 8'h80 + 8'(i));
            if (bus.valid_out) begin
                nv++;
                outs.push_back(bus.data_out);
            end
        end
        check("stream_no_gaps", 32'(nv), 32'd7);
        check("stream_w0", 32'(outs[0]), 32'h00);
        check("stream_w1", 32'(outs[1]), 32'h80);
        check("stream_w2", 32'(outs[2]), 32'h01);
        check("stream_w3", 32'(outs[3]), 32'h81);
        repeat (4) idle();

        // Mid-stream reset with three words queued.
        pulse_reset();
        drive(1'b1, 8'h51, 1'b1, 8'h61);
        drive(1'b1, 8'h52, 1'b1, 8'h62);
        bus.valid_in_0 = 1'b0;
        bus.valid_in_1 = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_data",  32'(bus.data_out),  32'h00);
        check("mid_rst_valid", 32'(bus.valid_out), 32'h0);
        check("mid_rst_ovf",   32'(bus.overflow),  32'h0);
        check("mid_rst_rdy0",  32'(bus.ready_0),   32'h1);
        check("mid_rst_rdy1",  32'(bus.ready_1),   32'h1);
        @(posedge clk_2f);
        #1;
        reset = 1'b1;
        idle();
        check("post_rst_a", 32'(bus.valid_out), 32'h0);
        idle();
        check("post_rst_b", 32'(bus.valid_out), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 8'h77);
        idle();
        check("post_rst_l1_only", 32'(bus.valid_out), 32'h0);
        drive(1'b1, 8'h78, 1'b0, 8'h00);
        idle();
        check("post_rst_first", 32'(bus.data_out), 32'h78);
        idle();
        check("post_rst_second", 32'(bus.data_out), 32'h77);

        // Randomized traffic with varying load and occasional async reset pulses.
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            int dens0;
            int dens1;
            dens0 = (i / 100) % 3;
            dens1 = ((i / 100) + 1) % 3;
            drive($urandom_range(0, 3) < 32'(dens0 + 1),
                  8'($urandom),
                  $urandom_range(0, 3) < 32'(dens1 + 1),
                  8'($urandom));
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
        end
        repeat (12) idle();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
